// File: rtl/move_source_arbiter.sv
// Round-robin arbiter sharing one move sequencer among NUM_REQ sources: load the winner's
// 50-move sequence, start it, wait for completion or a watchdog abort, then ack the source.
module move_source_arbiter #(
  parameter int              NUM_REQ      = 3,
  parameter int              ID_W         = 2,
  parameter int              TO_W         = 32,
  parameter logic [TO_W-1:0] RUN_TIMEOUT  = 32'd1_000_000_000,
  parameter int              FILL_TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*200-1:0] req_seq,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     ack,
  output logic [ID_W-1:0]        active_id,
  output logic                   busy,
  output logic                   err,
  input  logic                   err_clear,
  output logic [ID_W-1:0]        err_id,
  output logic [199:0]           seq,
  output logic                   new_moves,
  output logic                   seq_complete,
  output logic                   seq_reset,
  input  logic                   finished_queue,
  input  logic [7:0]             num_moves,
  input  logic                   seq_done
);
  localparam int SEQ_W = 200;
  localparam logic [TO_W-1:0] FILL_LIMIT = TO_W'(FILL_TIMEOUT - 1);
  localparam logic [TO_W-1:0] RUN_LIMIT  = RUN_TIMEOUT - 1'b1;
  localparam logic [TO_W-1:0] FILL_SKIP  = TO_W'(2);

  typedef enum logic [2:0] {IDLE, LOAD, FILL, CHECK, RUN, ABORT, DONE} state_t;

  state_t             state_q, state_d;
  logic [TO_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [ID_W-1:0]    last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [ID_W-1:0]    active_id_q, active_id_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [ID_W-1:0]    err_id_q, err_id_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic               new_moves_q, new_moves_d;
  logic               seq_complete_q, seq_complete_d;
  logic               seq_reset_q, seq_reset_d;

  logic               pick_vld;
  logic [ID_W-1:0]    pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic [SEQ_W-1:0]   pick_seq;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    pick_oh  = '0;
    pick_seq = '0;
    // Offsets walked farthest-first so the requester nearest after last_q is assigned last and wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && (i == ((int'(last_q) + k) % NUM_REQ))) begin
          pick_vld = 1'b1;
          pick_idx = ID_W'(i);
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == ID_W'(i)) begin
        pick_oh[i] = pick_vld;
        pick_seq   = req_seq[SEQ_W*i +: SEQ_W];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_inc        = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    cnt_d          = cnt_q;
    last_d         = last_q;
    grant_d        = grant_q;
    ack_d          = '0;
    active_id_d    = active_id_q;
    busy_d         = busy_q;
    err_d          = err_clear ? 1'b0 : err_q;
    err_id_d       = err_id_q;
    seq_d          = seq_q;
    new_moves_d    = 1'b0;
    seq_complete_d = 1'b0;
    seq_reset_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          seq_d       = pick_seq;
          grant_d     = pick_oh;
          active_id_d = pick_idx;
          busy_d      = 1'b1;
          new_moves_d = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = FILL;
      end
      FILL: begin
        cnt_d = cnt_inc;
        // The first two FILL cycles cover the sequencer's load latency.
        if ((cnt_q >= FILL_SKIP) && finished_queue) begin
          state_d = CHECK;
        end else if (cnt_q >= FILL_LIMIT) begin
          cnt_d       = '0;
          seq_reset_d = 1'b1;
          state_d     = ABORT;
        end
      end
      CHECK: begin
        if (num_moves == 8'd0) begin
          state_d = DONE;
        end else begin
          seq_complete_d = 1'b1;
          cnt_d          = '0;
          state_d        = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (seq_done) begin
          state_d = DONE;
        end else if (cnt_q >= RUN_LIMIT) begin
          cnt_d       = '0;
          seq_reset_d = 1'b1;
          state_d     = ABORT;
        end
      end
      ABORT: begin
        cnt_d = cnt_inc;
        if (cnt_q == '0) begin
          seq_reset_d = 1'b1;
        end else begin
          err_d    = 1'b1;
          err_id_d = active_id_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        ack_d   = grant_q;
        last_d  = active_id_q;
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      last_q         <= ID_W'(NUM_REQ - 1);
      grant_q        <= '0;
      ack_q          <= '0;
      active_id_q    <= '0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
      err_id_q       <= '0;
      seq_q          <= '0;
      new_moves_q    <= 1'b0;
      seq_complete_q <= 1'b0;
      seq_reset_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_q         <= last_d;
      grant_q        <= grant_d;
      ack_q          <= ack_d;
      active_id_q    <= active_id_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
      err_id_q       <= err_id_d;
      seq_q          <= seq_d;
      new_moves_q    <= new_moves_d;
      seq_complete_q <= seq_complete_d;
      seq_reset_q    <= seq_reset_d;
    end
  end

  assign grant        = grant_q;
  assign ack          = ack_q;
  assign active_id    = active_id_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign err_id       = err_id_q;
  assign seq          = seq_q;
  assign new_moves    = new_moves_q;
  assign seq_complete = seq_complete_q;
  assign seq_reset    = seq_reset_q;

endmodule

// File: tb/tb_move_source_arbiter.sv
// Directed bench for move_source_arbiter; the TB plays the sequencer and the three sources.
module tb_move_source_arbiter;
  logic         clock = 1'b0;
  logic         reset_n;
  logic [2:0]   req;
  logic [599:0] req_seq;
  logic [2:0]   grant;
  logic [2:0]   ack;
  logic [1:0]   active_id;
  logic         busy;
  logic         err;
  logic         err_clear;
  logic [1:0]   err_id;
  logic [199:0] seq;
  logic         new_moves;
  logic         seq_complete;
  logic         seq_reset;
  logic         finished_queue;
  logic [7:0]   num_moves;
  logic         seq_done;

  int n_tests = 0;
  int n_fail  = 0;

  move_source_arbiter #(
    .NUM_REQ(3), .ID_W(2), .TO_W(32), .RUN_TIMEOUT(32'd100), .FILL_TIMEOUT(64)
  ) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_seq(req_seq),
    .grant(grant), .ack(ack), .active_id(active_id), .busy(busy),
    .err(err), .err_clear(err_clear), .err_id(err_id), .seq(seq),
    .new_moves(new_moves), .seq_complete(seq_complete), .seq_reset(seq_reset),
    .finished_queue(finished_queue), .num_moves(num_moves), .seq_done(seq_done)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, 200'(grant), 200'd0);
    chk({tag, "_ack"}, 200'(ack), 200'd0);
    chk({tag, "_busy"}, 200'(busy), 200'd0);
    chk({tag, "_active_id"}, 200'(active_id), 200'd0);
    chk({tag, "_err"}, 200'(err), 200'd0);
    chk({tag, "_err_id"}, 200'(err_id), 200'd0);
    chk({tag, "_seq"}, seq, 200'd0);
    chk({tag, "_new_moves"}, 200'(new_moves), 200'd0);
    chk({tag, "_seq_complete"}, 200'(seq_complete), 200'd0);
    chk({tag, "_seq_reset"}, 200'(seq_reset), 200'd1);
  endtask

  int           w;
  logic         sc;
  logic [2:0]   exp_g;
  logic [199:0] three_moves;

  initial begin
    reset_n = 1'b0; req = '0; req_seq = '0; err_clear = 1'b0;
    finished_queue = 1'b1; num_moves = 8'd0; seq_done = 1'b0;
    three_moves = {4'h3, 4'h5, 4'h1, 188'd0};

    step(); step();
    chk_reset_vals("rst");
    reset_n = 1'b1;
    step();
    chk("rst_release_seq_reset", 200'(seq_reset), 200'd0);

    // Round robin over three held requests, empty sequences.
    req = 3'b111;
    for (int s = 0; s < 6; s++) begin
      exp_g = 3'(1 << (s % 3));
      w = 0;
      while (grant === 3'b000 && w < 30) begin step(); w++; end
      chk("rr_grant", 200'(grant), 200'(exp_g));
      chk("rr_active_id", 200'(active_id), 200'(s % 3));
      w = 0;
      while (ack === 3'b000 && w < 30) begin step(); w++; end
      chk("rr_ack", 200'(ack), 200'(exp_g));
      chk("rr_no_overlap", 200'(grant), 200'd0);
      if (s == 5) req = 3'b000;
      step();
      chk("rr_ack_width", 200'(ack), 200'd0);
    end

    // Empty sequence latency: sampled req edge to ack edge.
    req = 3'b001;
    step();
    chk("empty_grant", 200'(grant), 200'd1);
    w = 0; sc = 1'b0;
    while (ack !== 3'b001 && w < 20) begin
      step(); w++;
      if (seq_complete) sc = 1'b1;
    end
    req = 3'b000;
    chk("empty_latency", 200'(w), 200'd6);
    chk("empty_no_start", 200'(sc), 200'd0);

    // Stray seq_done while idle.
    seq_done = 1'b1;
    step();
    seq_done = 1'b0;
    step();
    chk("stray_done_busy", 200'(busy), 200'd0);
    chk("stray_done_ack", 200'(ack), 200'd0);

    // Single source 1, three moves, 40-cycle run.
    num_moves = 8'd3;
    req_seq = {200'h123, three_moves, 200'hABC};
    req = 3'b010;
    step();
    chk("s1_grant", 200'(grant), 200'd2);
    chk("s1_busy", 200'(busy), 200'd1);
    chk("s1_new_moves", 200'(new_moves), 200'd1);
    chk("s1_seq", seq, three_moves);
    req_seq = '0;
    step();
    chk("s1_new_moves_width", 200'(new_moves), 200'd0);
    w = 0;
    while (seq_complete !== 1'b1 && w < 20) begin step(); w++; end
    chk("s1_fill_to_start", 200'(w), 200'd4);
    step();
    chk("s1_start_width", 200'(seq_complete), 200'd0);
    chk("s1_seq_latched", seq, three_moves);
    for (int i = 0; i < 38; i++) step();
    seq_done = 1'b1;
    step();
    seq_done = 1'b0;
    chk("s1_ack_not_yet", 200'(ack), 200'd0);
    step();
    chk("s1_ack", 200'(ack), 200'd2);
    chk("s1_busy_low", 200'(busy), 200'd0);
    req = 3'b000;
    step();
    chk("s1_ack_width", 200'(ack), 200'd0);
    chk("s1_err", 200'(err), 200'd0);

    // Run hang on source 2; err_clear collides with the abort.
    num_moves = 8'd5;
    req_seq = {200'h77, 400'd0};
    req = 3'b100;
    step();
    chk("rh_grant", 200'(grant), 200'd4);
    w = 0;
    while (seq_complete !== 1'b1 && w < 20) begin step(); w++; end
    w = 0;
    while (seq_reset !== 1'b1 && w < 200) begin step(); w++; end
    chk("rh_timeout", 200'(w), 200'd100);
    step();
    chk("rh_seq_reset_2nd", 200'(seq_reset), 200'd1);
    err_clear = 1'b1;
    step();
    chk("rh_seq_reset_end", 200'(seq_reset), 200'd0);
    chk("rh_err_set_priority", 200'(err), 200'd1);
    chk("rh_err_id", 200'(err_id), 200'd2);
    step();
    chk("rh_ack", 200'(ack), 200'd4);
    chk("rh_err_cleared", 200'(err), 200'd0);
    err_clear = 1'b0;
    req = 3'b000;

    // Fill hang on source 0.
    finished_queue = 1'b0;
    req = 3'b001;
    step();
    chk("fh_grant", 200'(grant), 200'd1);
    step();
    w = 0; sc = 1'b0;
    while (seq_reset !== 1'b1 && w < 100) begin
      step(); w++;
      if (seq_complete) sc = 1'b1;
    end
    chk("fh_timeout", 200'(w), 200'd64);
    step(); step();
    chk("fh_err", 200'(err), 200'd1);
    chk("fh_err_id", 200'(err_id), 200'd0);
    chk("fh_no_start", 200'(sc | seq_complete), 200'd0);
    step();
    chk("fh_ack", 200'(ack), 200'd1);
    req = 3'b000;
    finished_queue = 1'b1;

    // Reset during RUN with two sources still requesting.
    num_moves = 8'd2;
    req = 3'b011;
    step();
    chk("rr_after_abort_grant", 200'(grant), 200'd2);
    w = 0;
    while (seq_complete !== 1'b1 && w < 20) begin step(); w++; end
    for (int i = 0; i < 5; i++) step();
    reset_n = 1'b0;
    step();
    chk_reset_vals("midrst");
    reset_n = 1'b1;
    step();
    chk("midrst_seq_reset_low", 200'(seq_reset), 200'd0);
    chk("midrst_no_ack", 200'(ack), 200'd0);
    chk("midrst_regrant", 200'(grant), 200'd1);
    req = 3'b000;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/move_source_arbiter.md
Name: move_source_arbiter

Overview:
- Shares the single move sequencer between NUM_REQ move sources, e.g. scramble generator, solver output and manual/UART entry.
- Grants one source at a time using round-robin.
- Loads the granted source's packed 50-move sequence into the sequencer, kicks execution, waits for completion, then acks the source.
- Includes fill and run watchdogs that reset the sequencer on a hang.

Parameters:
NUM_REQ, 3, number of move sources (2..4)
ID_W, 2, width of active_id; must satisfy 2^ID_W >= NUM_REQ
TO_W, 32, width of run watchdog counter
RUN_TIMEOUT, 32'd1_000_000_000, max cycles in RUN before abort
FILL_TIMEOUT, 64, max cycles waiting for queue fill; must exceed 50

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous reset, active-low
req  in  NUM_REQ  per-source request level; source holds it and its sequence until its ack
req_seq  in  NUM_REQ*200  packed sequences; source i occupies bits [200*i+199 : 200*i]; 4-bit moves, MSB nibble first, 0 = no move
grant  out  NUM_REQ  one-hot, high for the granted source throughout service
ack  out  NUM_REQ  one-cycle pulse to the served source at end of service
active_id  out  ID_W  index of the granted source; valid while busy
busy  out  1  high from grant until ack
err  out  1  sticky; set on any watchdog abort
err_clear  in  1  clears err, level-sensitive; set has priority
err_id  out  ID_W  source index latched at the last abort
seq  out  200  sequence presented to the sequencer
new_moves  out  1  one-cycle load strobe to the sequencer
seq_complete  out  1  one-cycle start strobe to the sequencer
seq_reset  out  1  active-high reset to the sequencer
finished_queue  in  1  sequencer idle / queue-fill-done status
num_moves  in  8  sequencer queued move count
seq_done  in  1  sequencer one-cycle completion pulse

Behaviour:
- Clocking and reset:
  - Single clock domain; all outputs are registered.
  - Reset is synchronous: reset_n sampled low at a posedge.
- Values while reset_n is low: grant=0, ack=0, busy=0, active_id=0, err=0, err_id=0, seq=0, new_moves=0, seq_complete=0, seq_reset=1, state=IDLE, round-robin pointer last=NUM_REQ-1. Source 0 therefore wins first.
- seq_reset drops to 0 on the first clock edge after reset_n is sampled high.
- State machine (IDLE, LOAD, FILL, CHECK, RUN, ABORT, DONE):
  - IDLE: if |req, pick the first requesting index scanning last+1, last+2, ... modulo NUM_REQ.
    - Latch seq from that slice and set grant, active_id and busy.
    - Set new_moves=1 and go to LOAD. new_moves is high during the LOAD cycle only.
  - LOAD: clear new_moves, clear the watchdog counter, go to FILL.
  - FILL: ignore finished_queue for the first 2 cycles, covering sequencer latency.
    - Then, on finished_queue=1, go to CHECK.
    - If the counter reaches FILL_TIMEOUT first, go to ABORT.
  - CHECK: if num_moves==0 (all-zero sequence), go to DONE without a start strobe.
    - Otherwise pulse seq_complete for exactly one cycle, clear the counter, go to RUN.
  - RUN: on seq_done=1, go to DONE. If the counter reaches RUN_TIMEOUT first, go to ABORT.
  - ABORT: assert seq_reset for exactly 2 cycles, set err, latch err_id=active_id, then go to DONE.
  - DONE: pulse ack[active_id] for one cycle, set last=active_id, clear grant and busy, return to IDLE.
    - A new grant may issue on the cycle after DONE.
- Ordering and latency:
  - Sequences are never interleaved; exactly one source is served per grant.
  - Latency from grant to new_moves is 0 cycles (same edge).
  - Minimum time from req to ack for an empty sequence is 6 cycles.
- Boundary conditions:
  - req deasserted mid-service: service still completes and ack is still issued.
  - req_seq changing mid-service: ignored; the sequence is latched at grant.
  - Simultaneous requests: round-robin order only; no starvation, so each source waits at most NUM_REQ-1 services.
  - A stray seq_done outside RUN is ignored.
  - finished_queue outside FILL is ignored.
  - err_clear in the same cycle as an abort: err remains set.
  - Watchdog counters saturate; they do not wrap.
  - reset_n low mid-service: immediate return to reset values. No ack is issued; the source must re-request.

Test Plan:
- Single source: req[1]=1 with 3 moves (seq MSBs 4'h3,4'h5,4'h1, rest 0), sequencer model returns seq_done 40 cycles after seq_complete -> new_moves pulse of width 1, seq_complete pulse of width 1 after finished_queue, ack[1] pulse 2 cycles after seq_done, err=0.
- Round-robin fairness: req=3'b111 held for 6 services, empty sequences -> grant order 0,1,2,0,1,2; each ack is a single cycle; grant one-hot with no gaps overlapping.
- Empty sequence: all-zero seq, model reports num_moves=0 -> seq_complete never asserted, ack issued, total req->ack = 6 cycles.
- Run hang: RUN_TIMEOUT=100, model never pulses seq_done, source 2 granted -> seq_reset high exactly 2 cycles, err=1, err_id=2, ack[2] pulses; err_clear=1 then clears err.
- Fill hang: model holds finished_queue=0, FILL_TIMEOUT=64 -> abort after 64 FILL cycles, err=1, no seq_complete issued.
- Reset mid-RUN: reset_n low for 1 cycle during RUN -> all outputs at reset values next cycle, seq_reset=1, no ack; with req still high, source 0 is granted first after release.
